sig_stream_ctrl: RTL and testbench

Stream-side issue controller that sits directly upstream of the sigmoid activation unit and also collects its results. It buffers FP32 operands from a valid/ready producer in a small FIFO and presents them one at a time on the unit's `x_in`/`start` pins. It waits a variable number of cycles for the unit's `valid`, then hands the result to a valid/ready consumer. A timeout guard returns a quiet NaN if the unit never responds.

---
 rtl/sig_pkg.sv | 13 +
 rtl/sig_sync_fifo.sv | 51 +++++
 rtl/sig_stream_ctrl.sv | 103 ++++++++++
 tb/tb_sig_stream_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// Shared types and constants for the sigmoid stream controller.
// Holds the FSM state encoding, the forced quiet-NaN result and default timing knobs.
package sig_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    DRAIN = 2'b10
  } sig_state_t;

  localparam logic [31:0] SIG_QNAN    = 32'h7FC00000;
  localparam int          SIG_TIMEOUT = 16;
  localparam int          SIG_GAP     = 2;
endpackage

// File: rtl/sig_sync_fifo.sv
// Synchronous FIFO with combinational head; one-cycle push-to-visible latency.
// Pushes are dropped when full and pops are ignored when empty; push and pop may coincide.
module sig_sync_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DWIDTH-1:0]        push_data,
  input  logic                     pop,
  output logic [DWIDTH-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/sig_stream_ctrl.sv
// Issues buffered operands to the sigmoid unit one at a time and returns its results downstream.
// Results wait in DRAIN until m_ready; a unit that never answers yields a flagged quiet NaN.
module sig_stream_ctrl
  import sig_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = SIG_TIMEOUT,
  parameter int GAP     = SIG_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DWIDTH-1:0] act_x,
  output logic              act_start,
  input  logic [DWIDTH-1:0] act_y,
  input  logic              act_valid,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_timeout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  sig_state_t        state_q;
  logic [TW-1:0]     timer_q;
  logic [CW-1:0]     cooldown_q;
  logic [DWIDTH-1:0] act_x_q, m_data_q;
  logic              act_start_q, m_valid_q, m_timeout_q;

  logic [DWIDTH-1:0]      fifo_head;
  logic                   fifo_full, fifo_empty, issue;
  logic [$clog2(DEPTH):0] fifo_count;

  assign issue     = (state_q == IDLE) && !fifo_empty && (cooldown_q == '0);
  assign s_ready   = !fifo_full;
  assign busy      = (fifo_count != '0) || (state_q != IDLE);
  assign act_x     = act_x_q;
  assign act_start = act_start_q;
  assign m_data    = m_data_q;
  assign m_timeout = m_timeout_q;
  assign m_valid   = m_valid_q;

  sig_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s_valid & s_ready),
    .push_data (s_data),
    .pop       (issue),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cooldown_q  <= '0;
      act_x_q     <= '0;
      act_start_q <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_timeout_q <= 1'b0;
    end else begin
      if (cooldown_q != '0) cooldown_q <= cooldown_q - CW'(1);
      case (state_q)
        IDLE: begin
          if (issue) begin
            act_x_q     <= fifo_head;
            act_start_q <= 1'b1;
            timer_q     <= '0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          timer_q <= timer_q + TW'(1);
          // A response on the expiry cycle still counts as a real result.
          if (act_valid || (timer_q == TW'(TIMEOUT - 1))) begin
            m_data_q    <= act_valid ? act_y : DWIDTH'(SIG_QNAN);
            m_timeout_q <= !act_valid;
            act_start_q <= 1'b0;
            m_valid_q   <= 1'b1;
            cooldown_q  <= CW'(GAP);
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sig_stream_ctrl.sv
// Directed bench for sig_stream_ctrl; the sigmoid unit is stubbed by driving act_valid/act_y.
module tb_sig_stream_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] act_x;
  logic        act_start;
  logic [31:0] act_y;
  logic        act_valid;
  logic [31:0] m_data;
  logic        m_timeout;
  logic        m_valid;
  logic        m_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int low_run = 0;
  int last_gap = 0;

  always #5 clk = ~clk;

  sig_stream_ctrl #(.DWIDTH(32), .DEPTH(4), .TIMEOUT(16), .GAP(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .act_x     (act_x),
    .act_start (act_start),
    .act_y     (act_y),
    .act_valid (act_valid),
    .m_data    (m_data),
    .m_timeout (m_timeout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy)
  );

  // Length of the most recent low stretch of act_start, measured mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      low_run = 0;
    end else if (!act_start) begin
      low_run = low_run + 1;
    end else begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!act_start && n < 64) begin
      n++;
      tick();
    end
    chk1("issue_seen", act_start, 1'b1);
  endtask

  // Wait for an issue, check operand, answer after lat cycles holding valid for hold cycles.
  task automatic serve(input logic [31:0] exp_x, input logic [31:0] y, input int lat, input int hold);
    wait_issue();
    chk32("issue_x", act_x, exp_x);
    repeat (lat - 1) tick();
    act_valid = 1'b1;
    act_y     = y;
    tick();
    chk1("res_valid", m_valid, 1'b1);
    chk32("res_data", m_data, y);
    chk1("res_tmo", m_timeout, 1'b0);
    chk1("res_start_low", act_start, 1'b0);
    repeat (hold - 1) tick();
    act_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; s_data = '0; s_valid = 1'b0; act_y = '0; act_valid = 1'b0; m_ready = 1'b0;
    #3;
    chk1("rst_start", act_start, 1'b0);
    chk1("rst_mvalid", m_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_sready", s_ready, 1'b1);
    chk32("rst_mdata", m_data, 32'h0);
    chk32("rst_actx", act_x, 32'h0);
    chk1("rst_tmo", m_timeout, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single op
    m_ready = 1'b1;
    push1(32'h3F800000);
    chk1("s1_busy", busy, 1'b1);
    chk1("s1_start_early", act_start, 1'b0);
    tick();
    chk1("s1_start", act_start, 1'b1);
    chk32("s1_x", act_x, 32'h3F800000);
    tick();
    chk32("s1_x_hold1", act_x, 32'h3F800000);
    chk1("s1_mvalid_early", m_valid, 1'b0);
    tick();
    chk32("s1_x_hold2", act_x, 32'h3F800000);
    chk1("s1_start_hold", act_start, 1'b1);
    act_valid = 1'b1; act_y = 32'h3F3B72AF;
    tick();
    act_valid = 1'b0;
    chk1("s1_mvalid", m_valid, 1'b1);
    chk32("s1_mdata", m_data, 32'h3F3B72AF);
    chk1("s1_tmo", m_timeout, 1'b0);
    chk1("s1_start_fall", act_start, 1'b0);
    tick();
    chk1("s1_handshake", m_valid, 1'b0);
    repeat (3) tick();

    // Backpressure / full
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h40000000;
    chk1("bp_ready0", s_ready, 1'b1);
    tick();
    s_data = 32'h40000001;
    tick();
    chk1("bp_start", act_start, 1'b1);
    chk32("bp_x0", act_x, 32'h40000000);
    s_data = 32'h40000002;
    tick();
    s_data = 32'h40000003;
    act_valid = 1'b1; act_y = 32'h3F111111;
    tick();
    act_valid = 1'b0;
    chk1("bp_mvalid", m_valid, 1'b1);
    chk32("bp_mdata", m_data, 32'h3F111111);
    chk1("bp_ready4", s_ready, 1'b1);
    s_data = 32'h40000004;
    tick();
    chk1("bp_full", s_ready, 1'b0);
    s_data = 32'h40000005;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk32("bp_stall_data", m_data, 32'h3F111111);
      chk1("bp_stall_valid", m_valid, 1'b1);
      chk1("bp_stall_full", s_ready, 1'b0);
      chk1("bp_stall_start", act_start, 1'b0);
    end
    m_ready = 1'b1;
    tick();
    chk1("bp_release", m_valid, 1'b0);
    chk1("bp_still_full", s_ready, 1'b0);
    tick();
    chk1("bp_issue1", act_start, 1'b1);
    chk32("bp_x1", act_x, 32'h40000001);
    chk1("bp_ready_back", s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
    serve(32'h40000001, 32'h3F222222, 1, 1);
    serve(32'h40000002, 32'h3F333333, 2, 1);
    serve(32'h40000003, 32'h3F444444, 1, 1);
    serve(32'h40000004, 32'h3F555555, 3, 1);
    serve(32'h40000005, 32'h3F666666, 1, 1);
    repeat (3) tick();
    chk1("bp_idle", busy, 1'b0);

    // Timeout
    push1(32'hC0000000);
    tick();
    chk1("to_start", act_start, 1'b1);
    repeat (15) tick();
    chk1("to_not_yet", m_valid, 1'b0);
    chk1("to_start_hold", act_start, 1'b1);
    tick();
    chk1("to_mvalid", m_valid, 1'b1);
    chk32("to_mdata", m_data, 32'h7FC00000);
    chk1("to_flag", m_timeout, 1'b1);
    chk1("to_start_fall", act_start, 1'b0);
    repeat (4) tick();

    // Race: response on the expiry cycle
    push1(32'h3F123456);
    tick();
    chk1("race_start", act_start, 1'b1);
    repeat (15) tick();
    act_valid = 1'b1; act_y = 32'h3F000000;
    tick();
    act_valid = 1'b0;
    chk1("race_mvalid", m_valid, 1'b1);
    chk32("race_mdata", m_data, 32'h3F000000);
    chk1("race_flag", m_timeout, 1'b0);
    repeat (4) tick();

    // Gap and order with a sticky valid
    s_valid = 1'b1;
    s_data = 32'h41000000; tick();
    s_data = 32'h41000001; tick();
    s_data = 32'h41000002; tick();
    s_valid = 1'b0;
    serve(32'h41000000, 32'h3F700000, 2, 4);
    serve(32'h41000001, 32'h3F710000, 2, 4);
    chk32("gap1", 32'(last_gap), 32'd3);
    serve(32'h41000002, 32'h3F720000, 2, 4);
    chk32("gap2", 32'(last_gap), 32'd3);
    repeat (3) tick();

    // Reset mid-WAIT
    push1(32'h3E000000);
    tick();
    tick();
    chk1("rw_busy", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk1("rw_start", act_start, 1'b0);
    chk1("rw_mvalid", m_valid, 1'b0);
    chk1("rw_busy0", busy, 1'b0);
    chk1("rw_sready", s_ready, 1'b1);
    chk32("rw_actx", act_x, 32'h0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("rw_quiet_start", act_start, 1'b0);
      chk1("rw_quiet_valid", m_valid, 1'b0);
      chk1("rw_quiet_busy", busy, 1'b0);
    end
    push1(32'h3D000000);
    serve(32'h3D000000, 32'h3F0A0A0A, 1, 1);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
